// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Bit-serial 64-bit shifter for the ALU shift path (LSL / LSR, optional ASR).
//   A start accepted in IDLE or DONE latches the operand, shift amount and op.
//   RUN then produces one result bit per cycle through a 64:1 bit selector.
//   done pulses for one cycle 64 edges after the accept.
//
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     start    request, sampled on the rising edge
//     op       00 LSL, 01 LSR, 10 ASR (only when built with ASR), 11 reserved
//     data_in  64-bit operand, latched on accept
//     shamt    shift amount 0..63, latched on accept
//     result   shifted value, valid while done=1 and held until the next accept
//     busy     high while computing
//     done     single-cycle completion pulse
//
//   Build option: define SEQ_SHIFT_ASR_EN to make op 10 an arithmetic right
//   shift. Without it, op 10 gives an all-zero result with normal timing.

module seq_shift_unit #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [CNT_W-1:0] shamt,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] a;
   logic [CNT_W-1:0] sh;
   logic [1:0]       opr;

   logic [CNT_W-1:0] lsl_src;
   logic [CNT_W:0]   rsh_src;   // one bit wider so count+shamt cannot wrap
   logic             sel_bit;

   assign lsl_src = count - sh;
   assign rsh_src = {1'b0, count} + {1'b0, sh};

   always_comb begin
      sel_bit = 1'b0;
      case (opr)
         2'b00: if (count >= sh) sel_bit = a[lsl_src];
         2'b01: if (!rsh_src[CNT_W]) sel_bit = a[rsh_src[CNT_W-1:0]];
`ifdef SEQ_SHIFT_ASR_EN
         2'b10: sel_bit = rsh_src[CNT_W] ? a[WIDTH-1] : a[rsh_src[CNT_W-1:0]];
`endif
         default: sel_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         a      <= '0;
         sh     <= '0;
         opr    <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               result[count] <= sel_bit;
               count         <= count + 1'b1;   // wraps to 0 after the last bit
               if (count == CNT_W'(WIDTH - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            default: begin   // IDLE and DONE both accept a new request
               done <= 1'b0;
               if (start) begin
                  a      <= data_in;
                  sh     <= shamt;
                  opr    <= op;
                  result <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit
//   Directed self-checking bench for seq_shift_unit. Inputs are driven and
//   outputs sampled 1 time unit after the rising edge.

module tb_seq_shift_unit;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [63:0] data_in;
   logic [5:0]  shamt;
   logic [63:0] result;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   seq_shift_unit #(.WIDTH(64), .CNT_W(6)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .data_in (data_in),
      .shamt   (shamt),
      .result  (result),
      .busy    (busy),
      .done    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Accept one request, then count edges until done is seen (bounded).
   // Returns the number of edges after the accept edge, and busy just after accept.
   task automatic run_op(input logic [1:0] o, input logic [63:0] d, input logic [5:0] s,
                         output int n, output logic busy_after_accept);
      op      = o;
      data_in = d;
      shamt   = s;
      start   = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      busy_after_accept = busy;
      n = 0;
      while (n < 200) begin
         @(posedge clock); #1;
         n++;
         if (done) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      data_in = '0;
      shamt   = '0;
      #12;
      n_checks++;
      if (result !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: result=%h busy=%b done=%b expected 0/0/0", result, busy, done);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_lsl();
      int n; logic b;
      run_op(2'b00, 64'h0000_0000_0000_00FF, 6'd8, n, b);
      n_checks++;
      if (b !== 1'b1) begin n_fail++; $display("FAIL lsl_busy_after_accept: got %b expected 1", b); end
      n_checks++;
      if (n !== 64) begin n_fail++; $display("FAIL lsl_latency: got %0d edges expected 64", n); end
      n_checks++;
      if (result !== 64'h0000_0000_0000_FF00) begin
         n_fail++; $display("FAIL lsl_result: got %h expected %h", result, 64'h0000_0000_0000_FF00);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL lsl_busy_at_done: got %b expected 0", busy); end
      @(posedge clock); #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse: got %b expected 0", done); end

      run_op(2'b00, 64'hA5A5_0123_4567_89AB, 6'd0, n, b);
      n_checks++;
      if (result !== 64'hA5A5_0123_4567_89AB) begin
         n_fail++; $display("FAIL lsl_shamt0: got %h expected %h", result, 64'hA5A5_0123_4567_89AB);
      end
      run_op(2'b00, 64'h0000_0000_0000_0003, 6'd63, n, b);
      n_checks++;
      if (result !== 64'h8000_0000_0000_0000) begin
         n_fail++; $display("FAIL lsl_shamt63: got %h expected %h", result, 64'h8000_0000_0000_0000);
      end
   endtask

   task automatic test_lsr_boundary();
      int n; logic b;
      run_op(2'b01, 64'h8000_0000_0000_0001, 6'd63, n, b);
      n_checks++;
      if (result !== 64'h0000_0000_0000_0001) begin
         n_fail++; $display("FAIL lsr_shamt63: got %h expected %h", result, 64'h1);
      end
      run_op(2'b01, 64'h8000_0000_0000_0001, 6'd0, n, b);
      n_checks++;
      if (result !== 64'h8000_0000_0000_0001) begin
         n_fail++; $display("FAIL lsr_shamt0: got %h expected %h", result, 64'h8000_0000_0000_0001);
      end
      run_op(2'b01, 64'hF000_0000_0000_0000, 6'd4, n, b);
      n_checks++;
      if (result !== 64'h0F00_0000_0000_0000) begin
         n_fail++; $display("FAIL lsr_no_sign_fill: got %h expected %h", result, 64'h0F00_0000_0000_0000);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int n2;
      op      = 2'b00;
      data_in = 64'h0000_0000_0000_00FF;
      shamt   = 6'd8;
      start   = 1'b1;
      @(posedge clock); #1;           // accept edge
      n = 0;
      while (n < 200) begin
         @(posedge clock); #1;
         n++;
         if (n == 10) begin
            data_in = 64'h0000_0000_0000_DEAD;
            shamt   = 6'd3;
         end
         if (done) break;
      end
      n_checks++;
      if (n !== 64) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 64", n); end
      n_checks++;
      if (result !== 64'h0000_0000_0000_FF00) begin
         n_fail++; $display("FAIL b2b_first_result: got %h expected %h", result, 64'h0000_0000_0000_FF00);
      end
      // start is still high in the DONE cycle: next edge is a new accept
      @(posedge clock); #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++; $display("FAIL b2b_reaccept: busy=%b done=%b expected 1/0", busy, done);
      end
      n2 = 1;
      while (n2 < 200) begin
         @(posedge clock); #1;
         n2++;
         if (done) break;
      end
      n_checks++;
      if (n2 !== 65) begin n_fail++; $display("FAIL b2b_second_spacing: got %0d expected 65", n2); end
      n_checks++;
      if (result !== 64'h0000_0000_0006_F568) begin
         n_fail++; $display("FAIL b2b_second_result: got %h expected %h", result, 64'h0000_0000_0006_F568);
      end
   endtask

   task automatic test_asr_reserved();
      int n; logic b;
      logic [63:0] exp_asr;
`ifdef SEQ_SHIFT_ASR_EN
      exp_asr = 64'hFF00_0000_0000_0000;
`else
      exp_asr = 64'h0;
`endif
      run_op(2'b10, 64'hF000_0000_0000_0000, 6'd4, n, b);
      n_checks++;
      if (n !== 64) begin n_fail++; $display("FAIL asr_latency: got %0d expected 64", n); end
      n_checks++;
      if (result !== exp_asr) begin
         n_fail++; $display("FAIL asr_result: got %h expected %h", result, exp_asr);
      end
      run_op(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, n, b);
      n_checks++;
      if (n !== 64) begin n_fail++; $display("FAIL reserved_latency: got %0d expected 64", n); end
      n_checks++;
      if (result !== 64'h0) begin
         n_fail++; $display("FAIL reserved_result: got %h expected %h", result, 64'h0);
      end
   endtask

   task automatic test_reset_mid_run();
      logic seen_done;
      op      = 2'b00;
      data_in = 64'hFFFF_FFFF_FFFF_FFFF;
      shamt   = 6'd4;
      start   = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (20) @(posedge clock);
      #3;
      n_checks++;
      if (busy !== 1'b1 || result === 64'h0) begin
         n_fail++; $display("FAIL midrun_progress: busy=%b result=%h expected busy 1, nonzero result", busy, result);
      end
      reset_n = 1'b0;               // asserted between edges
      #1;
      n_checks++;
      if (result !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL midrun_reset: result=%h busy=%b done=%b expected 0/0/0", result, busy, done);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      seen_done = 1'b0;
      repeat (100) begin
         @(posedge clock); #1;
         if (done || busy) seen_done = 1'b1;
      end
      n_checks++;
      if (seen_done !== 1'b0) begin
         n_fail++; $display("FAIL midrun_no_done: got activity %b expected 0", seen_done);
      end
   endtask

   initial begin
      test_reset();
      test_lsl();
      test_lsr_boundary();
      test_back_to_back();
      test_asr_reserved();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
